// File: rtl/sirius_exp_pkg.sv
// Shared types for the exception sequencer: FSM states, event kinds, ExcCodes, exception record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sirius_exp_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    COMMIT   = 2'd2,
    REDIRECT = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    EV_EXC  = 2'd0,
    EV_IRQ  = 2'd1,
    EV_ERET = 2'd2
  } ev_kind_e;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;

  // Latched exception record; for ERET the epc field carries the return target.
  typedef struct packed {
    logic [4:0]  code;
    logic [31:0] epc;
    logic        bd;
    logic [31:0] bad_vaddr;
    logic        bad_vaddr_wen;
  } exp_rec_t;

endpackage

// File: rtl/exp_event_arbiter.sv
// Qualifies CP0 interrupts and picks one event per cycle: exception > interrupt > ERET.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; the caller decides whether the selected event is accepted.
// Ports: detector record in, CP0 interrupt state in, ERET + cp0_epc in; ev_vld/ev_kind/ev_rec out.
module exp_event_arbiter
  import sirius_exp_pkg::*;
#(
  parameter int INT_LINES = 6
) (
  input  logic                 exp_detect,
  input  logic [4:0]           exp_code,
  input  logic [31:0]          exp_epc,
  input  logic                 exp_bd,
  input  logic [31:0]          exp_bad_vaddr,
  input  logic                 exp_bad_vaddr_wen,
  input  logic                 eret,
  input  logic                 inst_valid,
  input  logic [31:0]          int_epc,
  input  logic                 int_bd,
  input  logic [31:0]          cp0_epc,
  input  logic                 cp0_status_ie,
  input  logic                 cp0_status_exl,
  input  logic [INT_LINES-1:0] cp0_int_pending,
  input  logic [INT_LINES-1:0] cp0_int_mask,
  output logic                 ev_vld,
  output ev_kind_e             ev_kind,
  output exp_rec_t             ev_rec
);

  logic irq;

  // Interrupts are only taken on a real instruction so EPC points at something restartable.
  assign irq = cp0_status_ie & ~cp0_status_exl & (|(cp0_int_pending & cp0_int_mask)) & inst_valid;

  always_comb begin
    ev_vld  = 1'b0;
    ev_kind = EV_EXC;
    ev_rec  = '0;
    if (exp_detect) begin
      ev_vld               = 1'b1;
      ev_kind              = EV_EXC;
      ev_rec.code          = exp_code;
      ev_rec.epc           = exp_epc;
      ev_rec.bd            = exp_bd;
      ev_rec.bad_vaddr     = exp_bad_vaddr;
      ev_rec.bad_vaddr_wen = exp_bad_vaddr_wen;
    end else if (irq) begin
      ev_vld      = 1'b1;
      ev_kind     = EV_IRQ;
      ev_rec.code = EXC_INT;
      ev_rec.epc  = int_epc;
      ev_rec.bd   = int_bd;
    end else if (eret) begin
      ev_vld     = 1'b1;
      ev_kind    = EV_ERET;
      ev_rec.epc = cp0_epc;
    end
  end

endmodule

// File: rtl/exception_sequencer.sv
// Precise exception/interrupt/ERET sequencer: capture, drain EX/MEM stall, one CP0 commit, flush, PC redirect.
// Latency: event -> cp0 commit 1 cycle (+ stall cycles), -> pc_redirect 2 cycles min; redirect held until ack.
// Backpressure: waits on ex_mem_stall before committing; holds pc_redirect until redirect_ack; new events ignored while busy.
// Ports: clk, rst (sync, active-low); detector/CP0/ERET inputs; busy, pipe_flush, pc_redirect/redirect_target,
//        cp0_exp_en/cp0_exl_clean pulses, latched cp0_exp_* record, exp_count.
// Optional: define EXP_STAT_CNT_EN to enable the exp_count statistics counter (otherwise tied to 0).
module exception_sequencer
  import sirius_exp_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'hbfc00380,
  parameter int          INT_LINES  = 6,
  parameter int          CNT_W      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ex_mem_stall,
  input  logic                 exp_detect,
  input  logic [4:0]           exp_code,
  input  logic [31:0]          exp_epc,
  input  logic                 exp_bd,
  input  logic [31:0]          exp_bad_vaddr,
  input  logic                 exp_bad_vaddr_wen,
  input  logic                 eret,
  input  logic                 inst_valid,
  input  logic [31:0]          int_epc,
  input  logic                 int_bd,
  input  logic [31:0]          cp0_epc,
  input  logic                 cp0_status_ie,
  input  logic                 cp0_status_exl,
  input  logic [INT_LINES-1:0] cp0_int_pending,
  input  logic [INT_LINES-1:0] cp0_int_mask,
  input  logic                 redirect_ack,
  output logic                 busy,
  output logic                 pipe_flush,
  output logic                 pc_redirect,
  output logic [31:0]          redirect_target,
  output logic                 cp0_exp_en,
  output logic                 cp0_exl_clean,
  output logic [4:0]           cp0_exp_code,
  output logic [31:0]          cp0_exp_epc,
  output logic                 cp0_exp_bd,
  output logic [31:0]          cp0_exp_bad_vaddr,
  output logic                 cp0_exp_bad_vaddr_wen,
  output logic [CNT_W-1:0]     exp_count
);

  state_e   state_q, state_d;
  ev_kind_e kind_q, kind_d;
  exp_rec_t rec_q, rec_d;

  logic     ev_vld;
  ev_kind_e ev_kind;
  exp_rec_t ev_rec;

  exp_event_arbiter #(.INT_LINES(INT_LINES)) u_arb (
    .exp_detect        (exp_detect),
    .exp_code          (exp_code),
    .exp_epc           (exp_epc),
    .exp_bd            (exp_bd),
    .exp_bad_vaddr     (exp_bad_vaddr),
    .exp_bad_vaddr_wen (exp_bad_vaddr_wen),
    .eret              (eret),
    .inst_valid        (inst_valid),
    .int_epc           (int_epc),
    .int_bd            (int_bd),
    .cp0_epc           (cp0_epc),
    .cp0_status_ie     (cp0_status_ie),
    .cp0_status_exl    (cp0_status_exl),
    .cp0_int_pending   (cp0_int_pending),
    .cp0_int_mask      (cp0_int_mask),
    .ev_vld            (ev_vld),
    .ev_kind           (ev_kind),
    .ev_rec            (ev_rec)
  );

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    rec_d   = rec_q;
    unique case (state_q)
      IDLE: begin
        // Capture only here: once busy the pipe is being flushed, so later events are stale.
        if (ev_vld) begin
          kind_d  = ev_kind;
          rec_d   = ev_rec;
          state_d = ex_mem_stall ? DRAIN : COMMIT;
        end
      end
      DRAIN:    if (!ex_mem_stall) state_d = COMMIT;
      COMMIT:   state_d = REDIRECT;
      REDIRECT: if (redirect_ack) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      kind_q  <= EV_EXC;
      rec_q   <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      rec_q   <= rec_d;
    end
  end

  // Outputs decode flops only, so nothing reaches them combinationally from inputs.
  assign busy                  = (state_q != IDLE);
  assign pipe_flush            = (state_q != IDLE);
  assign cp0_exp_en            = (state_q == COMMIT) && (kind_q != EV_ERET);
  assign cp0_exl_clean         = (state_q == COMMIT) && (kind_q == EV_ERET);
  assign pc_redirect           = (state_q == REDIRECT);
  assign redirect_target       = (state_q != REDIRECT) ? 32'h0 :
                                 (kind_q == EV_ERET)   ? rec_q.epc : EXC_VECTOR;
  assign cp0_exp_code          = rec_q.code;
  assign cp0_exp_epc           = rec_q.epc;
  assign cp0_exp_bd            = rec_q.bd;
  assign cp0_exp_bad_vaddr     = rec_q.bad_vaddr;
  assign cp0_exp_bad_vaddr_wen = cp0_exp_en & rec_q.bad_vaddr_wen;

`ifdef EXP_STAT_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts taken exceptions and interrupts; ERET does not count. Wraps naturally.
  always_comb begin
    cnt_d = cnt_q;
    if (cp0_exp_en) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign exp_count = cnt_q;
`else
  assign exp_count = '0;
`endif

endmodule

// File: tb/tb_exception_sequencer.sv
// Bench for exception_sequencer: directed cycle table, a hand-written stalled ADEL sequence,
// then randomized traffic, all checked every cycle against a transaction-level reference model.
module tb_exception_sequencer;

  localparam logic [31:0] VEC      = 32'hbfc00380;
  localparam logic [31:0] ERET_TGT = 32'hbfc00200;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_mem_stall, exp_detect, exp_bd, exp_bad_vaddr_wen, eret, inst_valid, int_bd;
  logic [4:0]  exp_code;
  logic [31:0] exp_epc, exp_bad_vaddr, int_epc, cp0_epc;
  logic        cp0_status_ie, cp0_status_exl, redirect_ack;
  logic [5:0]  cp0_int_pending, cp0_int_mask;
  logic        busy, pipe_flush, pc_redirect, cp0_exp_en, cp0_exl_clean, cp0_exp_bd, cp0_exp_bad_vaddr_wen;
  logic [31:0] redirect_target, cp0_exp_epc, cp0_exp_bad_vaddr, exp_count;
  logic [4:0]  cp0_exp_code;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  exception_sequencer dut (
    .clk(clk), .rst(rst), .ex_mem_stall(ex_mem_stall), .exp_detect(exp_detect), .exp_code(exp_code),
    .exp_epc(exp_epc), .exp_bd(exp_bd), .exp_bad_vaddr(exp_bad_vaddr), .exp_bad_vaddr_wen(exp_bad_vaddr_wen),
    .eret(eret), .inst_valid(inst_valid), .int_epc(int_epc), .int_bd(int_bd), .cp0_epc(cp0_epc),
    .cp0_status_ie(cp0_status_ie), .cp0_status_exl(cp0_status_exl), .cp0_int_pending(cp0_int_pending),
    .cp0_int_mask(cp0_int_mask), .redirect_ack(redirect_ack), .busy(busy), .pipe_flush(pipe_flush),
    .pc_redirect(pc_redirect), .redirect_target(redirect_target), .cp0_exp_en(cp0_exp_en),
    .cp0_exl_clean(cp0_exl_clean), .cp0_exp_code(cp0_exp_code), .cp0_exp_epc(cp0_exp_epc),
    .cp0_exp_bd(cp0_exp_bd), .cp0_exp_bad_vaddr(cp0_exp_bad_vaddr),
    .cp0_exp_bad_vaddr_wen(cp0_exp_bad_vaddr_wen), .exp_count(exp_count)
  );

  // Reference model: an in-flight event goes through "waiting for stall", "commit now",
  // "redirecting" phases, tracked with plain flags.
  bit          m_active, m_commit_now, m_committed;
  int          m_kind;          // 0 exception, 1 interrupt, 2 eret
  logic [4:0]  m_code;
  logic [31:0] m_epc, m_bad, m_cnt;
  logic        m_bd, m_wen;

  task automatic model_step();
    bit irq;
    irq = cp0_status_ie && !cp0_status_exl && ((cp0_int_pending & cp0_int_mask) != 6'd0) && inst_valid;
    if (!rst) begin
      m_active = 0; m_commit_now = 0; m_committed = 0; m_kind = 0;
      m_code = '0; m_epc = '0; m_bd = 0; m_bad = '0; m_wen = 0; m_cnt = '0;
    end else if (!m_active) begin
      if (exp_detect || irq || eret) begin
        m_active = 1; m_commit_now = !ex_mem_stall; m_committed = 0;
        if (exp_detect) begin
          m_kind = 0; m_code = exp_code; m_epc = exp_epc; m_bd = exp_bd;
          m_bad = exp_bad_vaddr; m_wen = exp_bad_vaddr_wen;
        end else if (irq) begin
          m_kind = 1; m_code = 5'h00; m_epc = int_epc; m_bd = int_bd; m_bad = '0; m_wen = 0;
        end else begin
          m_kind = 2; m_code = 5'h00; m_epc = cp0_epc; m_bd = 0; m_bad = '0; m_wen = 0;
        end
      end
    end else if (m_commit_now) begin
      m_commit_now = 0; m_committed = 1;
      if (m_kind != 2) m_cnt = m_cnt + 1;
    end else if (m_committed) begin
      if (redirect_ack) begin m_active = 0; m_committed = 0; end
    end else if (!ex_mem_stall) begin
      m_commit_now = 1;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_model();
    logic en, cl, rd, bw;
    logic [31:0] tgt, cnt;
    en  = m_active && m_commit_now && (m_kind != 2);
    cl  = m_active && m_commit_now && (m_kind == 2);
    rd  = m_active && m_committed;
    bw  = en && m_wen;
    tgt = !rd ? 32'h0 : (m_kind == 2) ? m_epc : VEC;
`ifdef EXP_STAT_CNT_EN
    cnt = m_cnt;
`else
    cnt = 32'h0;
`endif
    chk("model_ctrl", 32'({busy, pipe_flush, cp0_exp_en, cp0_exl_clean, pc_redirect, cp0_exp_bad_vaddr_wen, cp0_exp_bd}),
        32'({m_active, m_active, en, cl, rd, bw, m_bd}));
    chk("model_target", redirect_target, tgt);
    chk("model_code", 32'(cp0_exp_code), 32'(m_code));
    chk("model_epc", cp0_exp_epc, m_epc);
    chk("model_badva", cp0_exp_bad_vaddr, m_bad);
    chk("model_count", exp_count, cnt);
  endtask

  // Advance one clock: model consumes the inputs present before the edge, DUT sampled 1 after it.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk_model();
  endtask

  task automatic drive_quiet();
    rst = 1; ex_mem_stall = 0; exp_detect = 0; exp_code = 5'h0c; exp_epc = 32'hbfc00100; exp_bd = 0;
    exp_bad_vaddr = 32'h0; exp_bad_vaddr_wen = 0; eret = 0; inst_valid = 1; int_epc = 32'h80001234;
    int_bd = 1; cp0_epc = ERET_TGT; cp0_status_ie = 0; cp0_status_exl = 0;
    cp0_int_pending = 6'b000100; cp0_int_mask = 6'b000100; redirect_ack = 0;
  endtask

  // ev bits: [0] exception (OV), [1] interrupt enable (IP2 pending+masked), [2] eret
  typedef struct {
    bit rst; bit stall; bit [2:0] ev; bit exl; bit ack;
    bit e_busy; bit e_en; bit e_clean; bit e_redir; logic [31:0] e_tgt;
  } vec_t;

  vec_t vt[29];

  initial begin
    vt[0]  = '{1'b0,1'b0,3'd0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,32'h0};
    vt[1]  = '{1'b1,1'b0,3'd1,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,32'h0};
    vt[2]  = '{1'b1,1'b0,3'd0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1,VEC};
    vt[3]  = '{1'b1,1'b0,3'd0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1,VEC};
    vt[4]  = '{1'b1,1'b0,3'd0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,32'h0};
    vt[5]  = '{1'b1,1'b1,3'd1,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,32'h0};
    vt[6]  = '{1'b1,1'b1,3'd0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,32'h0};
    vt[7]  = '{1'b1,1'b1,3'd0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,32'h0};
    vt[8]  = '{1'b1,1'b0,3'd0,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,32'h0};
    vt[9]  = '{1'b1,1'b0,3'd0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1,VEC};
    vt[10] = '{1'b1,1'b0,3'd0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,32'h0};
    vt[11] = '{1'b1,1'b0,3'd2,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,32'h0};
    vt[12] = '{1'b1,1'b0,3'd0,1'b0,1'b1, 1'b1,1'b0,1'b0,1'b1,VEC};
    vt[13] = '{1'b1,1'b0,3'd0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,32'h0};
    vt[14] = '{1'b1,1'b0,3'd2,1'b1,1'b0, 1'b0,1'b0,1'b0,1'b0,32'h0};
    vt[15] = '{1'b1,1'b0,3'd4,1'b0,1'b0, 1'b1,1'b0,1'b1,1'b0,32'h0};
    vt[16] = '{1'b1,1'b0,3'd0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1,ERET_TGT};
    vt[17] = '{1'b1,1'b0,3'd0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,32'h0};
    vt[18] = '{1'b1,1'b0,3'd7,1'b0,1'b0, 1'b1,1'b1,1'b0,1'b0,32'h0};
    vt[19] = '{1'b1,1'b0,3'd1,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1,VEC};
    vt[20] = '{1'b1,1'b0,3'd4,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1,VEC};
    vt[21] = '{1'b1,1'b0,3'd1,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1,VEC};
    vt[22] = '{1'b1,1'b0,3'd2,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b1,VEC};
    vt[23] = '{1'b1,1'b0,3'd1,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,32'h0};
    vt[24] = '{1'b1,1'b0,3'd0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,32'h0};
    vt[25] = '{1'b1,1'b1,3'd1,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,32'h0};
    vt[26] = '{1'b0,1'b0,3'd0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,32'h0};
    vt[27] = '{1'b1,1'b0,3'd0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,32'h0};
    vt[28] = '{1'b1,1'b0,3'd0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,32'h0};

    drive_quiet();
    #1;

    // Directed cycle table
    for (int i = 0; i < 29; i++) begin
      drive_quiet();
      rst = vt[i].rst; ex_mem_stall = vt[i].stall; redirect_ack = vt[i].ack;
      exp_detect = vt[i].ev[0]; cp0_status_ie = vt[i].ev[1]; eret = vt[i].ev[2];
      cp0_status_exl = vt[i].exl;
      tick();
      chk($sformatf("tbl%0d_ctrl", i), 32'({busy, cp0_exp_en, cp0_exl_clean, pc_redirect}),
          32'({vt[i].e_busy, vt[i].e_en, vt[i].e_clean, vt[i].e_redir}));
      chk($sformatf("tbl%0d_target", i), redirect_target, vt[i].e_tgt);
    end

    // Stalled ADEL: 3 stall cycles, commit on the cycle after stall drops, bad address written
    drive_quiet();
    exp_detect = 1; exp_code = 5'h04; exp_bad_vaddr = 32'h80000003; exp_bad_vaddr_wen = 1; ex_mem_stall = 1;
    tick();
    chk("adel_drain", 32'({busy, cp0_exp_en}), 32'(2'b10));
    drive_quiet(); ex_mem_stall = 1;
    tick();
    tick();
    chk("adel_still_drain", 32'({busy, cp0_exp_en}), 32'(2'b10));
    drive_quiet();
    tick();
    chk("adel_commit", 32'({cp0_exp_en, cp0_exp_bad_vaddr_wen}), 32'(2'b11));
    chk("adel_code", 32'(cp0_exp_code), 32'h04);
    chk("adel_badva", cp0_exp_bad_vaddr, 32'h80000003);
    tick();
    chk("adel_redirect", 32'({pc_redirect, cp0_exp_bad_vaddr_wen}), 32'(2'b10));
    redirect_ack = 1;
    tick();
    redirect_ack = 0;
    chk("adel_idle_hold", 32'({busy, 3'b000, cp0_exp_code}), 32'h04);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst               = ($urandom_range(0, 59) != 0);
      ex_mem_stall      = ($urandom_range(0, 2) == 0);
      exp_detect        = ($urandom_range(0, 5) == 0);
      exp_code          = 5'($urandom);
      exp_epc           = $urandom;
      exp_bd            = 1'($urandom);
      exp_bad_vaddr     = $urandom;
      exp_bad_vaddr_wen = 1'($urandom);
      eret              = ($urandom_range(0, 6) == 0);
      inst_valid        = 1'($urandom);
      int_epc           = $urandom;
      int_bd            = 1'($urandom);
      cp0_epc           = $urandom;
      cp0_status_ie     = 1'($urandom);
      cp0_status_exl    = ($urandom_range(0, 3) == 0);
      cp0_int_pending   = 6'($urandom);
      cp0_int_mask      = 6'($urandom);
      redirect_ack      = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
